// File: rtl/dprintf_arbiter_pkg.sv
// Shared dprintf definitions: field widths, arbiter state encoding and a wrap helper.
package dprintf_arbiter_pkg;

  localparam int unsigned DPRINTF_ADDR_W = 16;
  localparam int unsigned DPRINTF_DATA_W = 64;
  localparam int unsigned DPRINTF_WORDS  = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } arb_state_e;

  // Index of the requester after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dprintf_arbiter_if.sv
// dprintf request bundle for N lanes; lane i fields at [W*i +: W]. Master drives the
// request, slave returns the per-lane ack.
interface dprintf_arbiter_if #(
  parameter int unsigned N = 1
);
  import dprintf_arbiter_pkg::*;

  logic [N-1:0]                valid;
  logic [DPRINTF_ADDR_W*N-1:0] address;
  logic [DPRINTF_DATA_W*N-1:0] data_0;
  logic [DPRINTF_DATA_W*N-1:0] data_1;
  logic [DPRINTF_DATA_W*N-1:0] data_2;
  logic [DPRINTF_DATA_W*N-1:0] data_3;
  logic [N-1:0]                ack;

  modport master (
    output valid, address, data_0, data_1, data_2, data_3,
    input  ack
  );

  modport slave (
    input  valid, address, data_0, data_1, data_2, data_3,
    output ack
  );

endinterface

// File: rtl/dprintf_rr_pick.sv
// Combinational round-robin picker: first valid bit searching upward from ptr_i, wrapping.
module dprintf_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   winner_o
);

  localparam logic [IDX_W:0] NumReqW = (IDX_W + 1)'(NUM_REQ);

  logic [IDX_W:0] idx;
  logic           found;

  // Scan NUM_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    any_o    = |valid_i;
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (idx >= NumReqW) begin
        idx = idx - NumReqW;
      end
      if (!found && valid_i[idx[IDX_W-1:0]]) begin
        found    = 1'b1;
        winner_o = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dprintf_arbiter.sv
// Round-robin arbiter sharing one dprintf sink between NUM_REQ requesters. The winner is
// registered and held on req_out until the sink acks; the requester gets a one-cycle ack.
module dprintf_arbiter
  import dprintf_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  dprintf_arbiter_if.slave  req_in,
  dprintf_arbiter_if.master req_out,
  output logic [IDX_W-1:0]  grant_id
);

  arb_state_e state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic vld_q, vld_d;
  logic [DPRINTF_ADDR_W-1:0] addr_q, addr_d;
  logic [DPRINTF_WORDS-1:0][DPRINTF_DATA_W-1:0] data_q, data_d;

  logic pick_any;
  logic [IDX_W-1:0] pick_winner;
  logic [DPRINTF_ADDR_W-1:0] sel_addr;
  logic [DPRINTF_WORDS-1:0][DPRINTF_DATA_W-1:0] sel_data;

  dprintf_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid_i  (req_in.valid),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .winner_o (pick_winner)
  );

  // Mux the winning requester's fields out of the packed lanes.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_winner == IDX_W'(i)) begin
        sel_addr    = req_in.address[DPRINTF_ADDR_W*i +: DPRINTF_ADDR_W];
        sel_data[0] = req_in.data_0[DPRINTF_DATA_W*i +: DPRINTF_DATA_W];
        sel_data[1] = req_in.data_1[DPRINTF_DATA_W*i +: DPRINTF_DATA_W];
        sel_data[2] = req_in.data_2[DPRINTF_DATA_W*i +: DPRINTF_DATA_W];
        sel_data[3] = req_in.data_3[DPRINTF_DATA_W*i +: DPRINTF_DATA_W];
      end
    end
  end

  // Next state: capture in IDLE, wait for the sink ack in HOLD. ack_d defaults to 0 so the
  // requester ack is a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = '0;
    vld_d   = vld_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          addr_d  = sel_addr;
          data_d  = sel_data;
          vld_d   = 1'b1;
          grant_d = pick_winner;
          ack_d   = NUM_REQ'(1) << pick_winner;
          ptr_d   = IDX_W'(rr_next(32'(pick_winner), NUM_REQ));
          state_d = StHold;
        end
      end
      StHold: begin
        // Address/data stay put after the ack; only valid drops.
        if (req_out.ack[0]) begin
          vld_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; async reset drops any in-flight request silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign req_out.valid   = vld_q;
  assign req_out.address = addr_q;
  assign req_out.data_0  = data_q[0];
  assign req_out.data_1  = data_q[1];
  assign req_out.data_2  = data_q[2];
  assign req_out.data_3  = data_q[3];
  assign req_in.ack      = ack_q;
  assign grant_id        = grant_q;

endmodule

// File: tb/tb_dprintf_arbiter.sv
// Bench for dprintf_arbiter: directed scenarios plus random traffic, all checked against a
// transaction-level reference model of the arbitration rules.
module tb_dprintf_arbiter;
  import dprintf_arbiter_pkg::*;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] grant_id;

  dprintf_arbiter_if #(.N(N)) req_in ();
  dprintf_arbiter_if #(.N(1)) req_out ();

  dprintf_arbiter #(.NUM_REQ(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_in   (req_in),
    .req_out  (req_out),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // Stimulus as seen by the DUT
  logic [N-1:0]    v;
  logic [N*16-1:0] a;
  logic [N*64-1:0] d0, d1, d2, d3;
  logic            ack_out;
  logic [N-1:0]    ack_prev;

  // Reference model
  logic        m_vld;
  int          m_ptr;
  logic [1:0]  m_grant;
  logic [N-1:0] m_ack;
  logic [15:0] m_addr;
  logic [63:0] m_d0, m_d1, m_d2, m_d3;
  int          grants[$];
  int          cyc, last_cap, cap_gap;
  logic        captured;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [N-1:0] vec, input int idx);
    logic [N-1:0] t;
    t = vec >> idx;
    return t[0];
  endfunction

  task automatic drive();
    req_in.valid   = v;
    req_in.address = a;
    req_in.data_0  = d0;
    req_in.data_1  = d1;
    req_in.data_2  = d2;
    req_in.data_3  = d3;
    req_out.ack    = ack_out;
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_ptr = 0; m_grant = '0; m_ack = '0;
    m_addr = '0; m_d0 = '0; m_d1 = '0; m_d2 = '0; m_d3 = '0;
    grants.delete();
    last_cap = 0; cap_gap = 0; captured = 1'b0;
  endtask

  task automatic compare();
    check("out_valid", 64'(req_out.valid), 64'(m_vld));
    check("address", 64'(req_out.address), 64'(m_addr));
    check("data_0", req_out.data_0, m_d0);
    check("data_1", req_out.data_1, m_d1);
    check("data_2", req_out.data_2, m_d2);
    check("data_3", req_out.data_3, m_d3);
    check("ack_in", 64'(req_in.ack), 64'(m_ack));
    check("grant_id", 64'(grant_id), 64'(m_grant));
    check("ack_onehot", 64'($countones(req_in.ack) <= 1), 64'd1);
  endtask

  // One clock: apply the arbitration rules to the inputs present at the edge, then compare.
  task automatic step();
    int w;
    @(posedge clk);
    m_ack    = '0;
    captured = 1'b0;
    if (!m_vld) begin
      if (v != '0) begin
        w = -1;
        for (int k = 0; k < int'(N); k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (w < 0 && bit_of(v, idx)) w = idx;
        end
        m_addr  = a[16*w +: 16];
        m_d0    = d0[64*w +: 64];
        m_d1    = d1[64*w +: 64];
        m_d2    = d2[64*w +: 64];
        m_d3    = d3[64*w +: 64];
        m_vld   = 1'b1;
        m_grant = 2'(w);
        m_ack   = 4'b0001 << w;
        m_ptr   = (w + 1) % N;
        grants.push_back(w);
        cap_gap  = cyc - last_cap;
        last_cap = cyc;
        captured = 1'b1;
      end
    end else if (ack_out) begin
      m_vld = 1'b0;
    end
    cyc++;
    #1;
    compare();
  endtask

  task automatic set_payload(input int i);
    a[16*i +: 16]  = 16'($urandom);
    d0[64*i +: 64] = {$urandom, $urandom};
    d1[64*i +: 64] = {$urandom, $urandom};
    d2[64*i +: 64] = {$urandom, $urandom};
    d3[64*i +: 64] = {$urandom, $urandom};
  endtask

  // Requesters finish the handshake one edge after their ack cycle, then raise new requests.
  task automatic cycle(input logic [N-1:0] raise, input logic ack);
    v = v & ~ack_prev;
    for (int i = 0; i < int'(N); i++) begin
      if (bit_of(raise, i) && !bit_of(v, i)) begin
        set_payload(i);
        v = v | (4'b0001 << i);
      end
    end
    ack_prev = m_ack;
    ack_out  = ack;
    drive();
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    v = '0; a = '0; d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    ack_out = 1'b0; ack_prev = '0;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    int caps;
    cyc = 0;
    reset_n = 1'b0;
    do_reset();

    // 1: single request with known payload
    v = 4'b0001; a[15:0] = 16'h0050; d0[63:0] = 64'h20202087_00000001; ack_out = 1'b0;
    drive();
    step();
    check("t1_valid", 64'(req_out.valid), 64'd1);
    check("t1_addr", 64'(req_out.address), 64'h0050);
    check("t1_data0", req_out.data_0, 64'h20202087_00000001);
    check("t1_ack", 64'(req_in.ack), 64'b0001);
    ack_prev = m_ack; ack_out = 1'b1; drive();
    step();
    check("t1_drop", 64'(req_out.valid), 64'd0);
    check("t1_ack_gone", 64'(req_in.ack), 64'd0);
    check("t1_addr_kept", 64'(req_out.address), 64'h0050);

    // 2: everyone requesting, sink always ready
    do_reset();
    for (int i = 0; i < 10; i++) cycle(4'b1111, 1'b1);
    check("t2_ngrants", 64'(grants.size()), 64'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++) begin
      check("t2_order", 64'(grants[i]), 64'(i % 4));
    end

    // 3: wrap from pointer 3 to requester 0, then back to 2
    do_reset();
    cycle(4'b0100, 1'b1);
    cycle(4'b0001, 1'b1);
    cycle(4'b0101, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    check("t3_ngrants", 64'(grants.size()), 64'd3);
    if (grants.size() == 3) begin
      check("t3_g0", 64'(grants[0]), 64'd2);
      check("t3_g1", 64'(grants[1]), 64'd0);
      check("t3_g2", 64'(grants[2]), 64'd2);
    end

    // 4: sink stalls 20 cycles; output must hold and no further ack
    do_reset();
    cycle(4'b0110, 1'b0);
    check("t4_first", 64'(grant_id), 64'd1);
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0000, 1'b0);
      check("t4_no_ack", 64'(req_in.ack), 64'd0);
    end
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    check("t4_second", 64'(grant_id), 64'd2);
    check("t4_ack2", 64'(req_in.ack), 64'b0100);

    // 5: async reset in the middle of HOLD
    do_reset();
    cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_valid", 64'(req_out.valid), 64'd0);
    check("t5_ack", 64'(req_in.ack), 64'd0);
    check("t5_grant", 64'(grant_id), 64'd0);
    check("t5_addr", 64'(req_out.address), 64'd0);
    v = '0; ack_prev = '0; ack_out = 1'b0; drive();
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle(4'b1111, 1'b1);
    check("t5_ptr0", 64'(grant_id), 64'd0);

    // 6: lone requester 3 re-presents one cycle after finishing each handshake
    do_reset();
    caps = 0;
    for (int i = 0; i < 13; i++) begin
      r = (!bit_of(v, 3) && !bit_of(ack_prev, 3)) ? 4'b1000 : 4'b0000;
      cycle(r, 1'b1);
      if (captured) begin
        check("t6_grant", 64'(grant_id), 64'd3);
        if (caps > 0) check("t6_spacing", 64'(cap_gap), 64'd3);
        caps++;
      end
    end
    check("t6_count", 64'(caps), 64'd5);

    // Random traffic: new requests, random sink stalls, occasional withdrawals
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = '0;
      for (int j = 0; j < int'(N); j++) begin
        if ($urandom_range(99) < 30) r = r | (4'b0001 << j);
        if (bit_of(v, j) && !bit_of(m_ack, j) && !bit_of(ack_prev, j) &&
            $urandom_range(99) < 3) begin
          v = v & ~(4'b0001 << j);
        end
      end
      cycle(r, 1'($urandom_range(99) < 55));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
